dummy_xif_issuer: RTL and testbench

// - CPU-side initiator of the X-IF link to the dummy accelerator.
// - Takes decoded offload requests (instr + rs1/rs2) and issues them on the issue channel.
// - Sends one commit per issued ID, tracks outstanding IDs in a scoreboard and

---
 rtl/dummy_accelerator_pkg.sv | 26 ++
 rtl/dummy_xif_scoreboard.sv | 59 +++++
 rtl/dummy_xif_issuer.sv | 154 +++++++++++++++
 tb/tb_dummy_xif_issuer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dummy_accelerator_pkg.sv
// dummy_accelerator_pkg: shared X-IF widths, tag/scoreboard types and issuer FSM states
package dummy_accelerator_pkg;

    localparam int unsigned X_ID_WIDTH           = 4;
    localparam int unsigned XLEN                 = 32;
    localparam int unsigned ADDR_WIDTH           = 5;
    localparam int unsigned MAX_INFLIGHT_DEFAULT = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [ADDR_WIDTH-1:0] rd;
    } TagType;

    typedef struct packed {
        logic   valid;
        logic   we;
        TagType tag;
    } ScbEntryType;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COMMIT
    } issuer_state_e;

endpackage

// File: rtl/dummy_xif_scoreboard.sv
// dummy_xif_scoreboard: tag store of outstanding X-IF IDs with an allocate port and a combinational lookup/free port
module dummy_xif_scoreboard
    import dummy_accelerator_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alloc_i,
    input  TagType                alloc_tag_i,
    input  logic                  alloc_we_i,
    input  logic                  free_i,
    input  logic [X_ID_WIDTH-1:0] lookup_id_i,
    output logic                  hit_o,
    output logic                  hit_we_o,
    output logic [ADDR_WIDTH-1:0] hit_rd_o
);

    localparam int unsigned IDX_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    ScbEntryType [MAX_INFLIGHT-1:0] entries_q, entries_d;
    logic [IDX_W-1:0]               hit_idx, free_idx;
    logic                           free_found;

    // Descending scan so the lowest matching/free index wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            if (entries_q[i].valid && entries_q[i].tag.id == lookup_id_i) begin
                hit_o   = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!entries_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign hit_we_o = entries_q[hit_idx].we;
    assign hit_rd_o = entries_q[hit_idx].tag.rd;

    // Allocation only targets slots free at the start of the cycle, so it never
    // collides with an entry being freed and a same-cycle result cannot hit it.
    always_comb begin
        entries_d = entries_q;
        if (free_i && hit_o) entries_d[hit_idx].valid = 1'b0;
        if (alloc_i && free_found) entries_d[free_idx] = '{valid: 1'b1, we: alloc_we_i, tag: alloc_tag_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) entries_q <= '0;
        else entries_q <= entries_d;
    end

endmodule

// File: rtl/dummy_xif_issuer.sv
// dummy_xif_issuer: X-IF initiator that issues offload requests, commits them and retires out-of-order results
module dummy_xif_issuer
    import dummy_accelerator_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [31:0]                           req_instr_i,
    input  logic [XLEN-1:0]                       req_rs1_i,
    input  logic [XLEN-1:0]                       req_rs2_i,
    output logic                                  issue_valid_o,
    input  logic                                  issue_ready_i,
    output logic [31:0]                           issue_instr_o,
    output logic [X_ID_WIDTH-1:0]                 issue_id_o,
    output logic [2*XLEN-1:0]                     issue_rs_o,
    input  logic                                  issue_accept_i,
    input  logic                                  issue_writeback_i,
    output logic                                  commit_valid_o,
    output logic [X_ID_WIDTH-1:0]                 commit_id_o,
    output logic                                  commit_kill_o,
    input  logic                                  result_valid_i,
    output logic                                  result_ready_o,
    input  logic [X_ID_WIDTH-1:0]                 result_id_i,
    input  logic [ADDR_WIDTH-1:0]                 result_rd_i,
    input  logic [XLEN-1:0]                       result_data_i,
    input  logic                                  result_we_i,
    output logic                                  wb_valid_o,
    output logic [ADDR_WIDTH-1:0]                 wb_rd_o,
    output logic [XLEN-1:0]                       wb_data_o,
    output logic                                  illegal_o,
    output logic                                  err_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight_o
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    issuer_state_e         state_q, state_d;
    logic [31:0]           instr_q, instr_d;
    logic [XLEN-1:0]       rs1_q, rs1_d, rs2_q, rs2_d;
    logic [X_ID_WIDTH-1:0] id_q, id_d;
    logic                  accept_q, accept_d, we_q, we_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic                  err_q, err_d;
    logic                  alloc, hit, hit_we, res_hit, bad;
    logic [ADDR_WIDTH-1:0] hit_rd;

    dummy_xif_scoreboard #(
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_scb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .alloc_i    (alloc),
        .alloc_tag_i('{id: id_q, rd: instr_q[11:7]}),
        .alloc_we_i (we_q),
        .free_i     (result_valid_i),
        .lookup_id_i(result_id_i),
        .hit_o      (hit),
        .hit_we_o   (hit_we),
        .hit_rd_o   (hit_rd)
    );

    assign req_ready_o    = ~rst_i && state_q == IDLE && inflight_q < CNT_W'(MAX_INFLIGHT);
    assign result_ready_o = ~rst_i;
    assign issue_valid_o  = state_q == ISSUE;
    assign issue_instr_o  = instr_q;
    assign issue_id_o     = id_q;
    assign issue_rs_o     = {rs2_q, rs1_q};
    assign commit_valid_o = state_q == COMMIT;
    assign commit_id_o    = id_q;
    assign commit_kill_o  = commit_valid_o && !accept_q;
    assign illegal_o      = commit_kill_o;
    assign alloc          = commit_valid_o && accept_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign err_o          = err_q;
    assign inflight_o     = inflight_q;

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        id_d     = id_q;
        accept_d = accept_q;
        we_d     = we_q;
        case (state_q)
            IDLE: if (req_valid_i && req_ready_o) begin
                instr_d = req_instr_i;
                rs1_d   = req_rs1_i;
                rs2_d   = req_rs2_i;
                state_d = ISSUE;
            end
            ISSUE: if (issue_ready_i) begin
                accept_d = issue_accept_i;
                we_d     = issue_writeback_i;
                state_d  = COMMIT;
            end
            COMMIT: begin
                id_d    = id_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A hit entry is freed even when the result is malformed.
    always_comb begin
        res_hit    = result_valid_i && hit;
        bad        = result_valid_i && (!hit || hit_rd != result_rd_i || (result_we_i && !hit_we));
        wb_valid_d = result_valid_i && !bad && result_we_i;
        wb_rd_d    = wb_valid_d ? hit_rd : wb_rd_q;
        wb_data_d  = wb_valid_d ? result_data_i : wb_data_q;
        err_d      = err_q || bad;
        inflight_d = inflight_q + CNT_W'(alloc) - CNT_W'(res_hit);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            id_q       <= '0;
            accept_q   <= 1'b0;
            we_q       <= 1'b0;
            inflight_q <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            id_q       <= id_d;
            accept_q   <= accept_d;
            we_q       <= we_d;
            inflight_q <= inflight_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_dummy_xif_issuer.sv
// tb_dummy_xif_issuer: directed and randomized checks of the X-IF issuer against a per-ID outstanding-table model
module tb_dummy_xif_issuer;
    import dummy_accelerator_pkg::*;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        req_valid_i = 1'b0, req_ready_o;
    logic [31:0] req_instr_i = '0;
    logic [31:0] req_rs1_i = '0, req_rs2_i = '0;
    logic        issue_valid_o, issue_ready_i = 1'b0;
    logic [31:0] issue_instr_o;
    logic [3:0]  issue_id_o;
    logic [63:0] issue_rs_o;
    logic        issue_accept_i = 1'b0, issue_writeback_i = 1'b0;
    logic        commit_valid_o, commit_kill_o;
    logic [3:0]  commit_id_o;
    logic        result_valid_i = 1'b0, result_ready_o;
    logic [3:0]  result_id_i = '0;
    logic [4:0]  result_rd_i = '0;
    logic [31:0] result_data_i = '0;
    logic        result_we_i = 1'b0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        illegal_o, err_o;
    logic [2:0]  inflight_o;

    always #5 clk_i = ~clk_i;

    dummy_xif_issuer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_instr_i(req_instr_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_instr_o(issue_instr_o),
        .issue_id_o(issue_id_o), .issue_rs_o(issue_rs_o), .issue_accept_i(issue_accept_i),
        .issue_writeback_i(issue_writeback_i),
        .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
        .result_valid_i(result_valid_i), .result_ready_o(result_ready_o), .result_id_i(result_id_i),
        .result_rd_i(result_rd_i), .result_data_i(result_data_i), .result_we_i(result_we_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .illegal_o(illegal_o), .err_o(err_o), .inflight_o(inflight_o)
    );

    int checks = 0, errors = 0;

    // Reference model: which IDs are outstanding and what they were tagged with.
    bit         live[16];
    bit         m_we[16];
    logic [4:0] m_rd[16];
    int         exp_id;
    bit         exp_err;

    function automatic int live_count();
        int n = 0;
        foreach (live[i]) n += int'(live[i]);
        return n;
    endfunction

    function automatic void model_reset();
        foreach (live[i]) live[i] = 1'b0;
        exp_id  = 0;
        exp_err = 1'b0;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b1;
        req_valid_i = 1'b0; issue_ready_i = 1'b0; result_valid_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic do_req(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                          input bit acc, input bit wb, output int id);
        int n = 0;
        int dly;
        id = -1;
        step();
        req_valid_i = 1'b1; req_instr_i = instr; req_rs1_i = rs1; req_rs2_i = rs2;
        sample();
        while (req_ready_o !== 1'b1 && n < 20) begin
            step();
            sample();
            n++;
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_timeout: got %b need 1", req_ready_o);
            req_valid_i = 1'b0;
            return;
        end
        step();
        req_valid_i = 1'b0;
        dly = $urandom_range(0, 2);
        for (int k = 0; k < dly; k++) begin
            sample();
            checks++;
            if (issue_valid_o !== 1'b1 || issue_instr_o !== instr || issue_rs_o !== {rs2, rs1}) begin
                errors++;
                $display("FAIL issue_hold: valid %b instr %h rs %h need 1 %h %h", issue_valid_o, issue_instr_o, issue_rs_o, instr, {rs2, rs1});
            end
            step();
        end
        issue_ready_i = 1'b1; issue_accept_i = acc; issue_writeback_i = wb;
        sample();
        checks++;
        if (issue_valid_o !== 1'b1 || issue_id_o !== 4'(exp_id) || issue_instr_o !== instr || issue_rs_o !== {rs2, rs1}) begin
            errors++;
            $display("FAIL issue: valid %b id %0d instr %h rs %h need 1 %0d %h %h", issue_valid_o, issue_id_o, issue_instr_o, issue_rs_o, exp_id, instr, {rs2, rs1});
        end
        step();
        issue_ready_i = 1'b0;
        sample();
        checks++;
        if (commit_valid_o !== 1'b1 || commit_id_o !== 4'(exp_id) || commit_kill_o !== !acc || illegal_o !== !acc) begin
            errors++;
            $display("FAIL commit: valid %b id %0d kill %b illegal %b need 1 %0d %b %b", commit_valid_o, commit_id_o, commit_kill_o, illegal_o, exp_id, !acc, !acc);
        end
        id = exp_id;
        if (acc) begin
            live[id] = 1'b1;
            m_we[id] = wb;
            m_rd[id] = instr[11:7];
        end
        exp_id = (exp_id + 1) % 16;
        step();
        sample();
        checks++;
        if (commit_valid_o !== 1'b0 || illegal_o !== 1'b0 || inflight_o !== 3'(live_count())) begin
            errors++;
            $display("FAIL post_commit: commit %b illegal %b inflight %0d need 0 0 %0d", commit_valid_o, illegal_o, inflight_o, live_count());
        end
    endtask

    task automatic send_result(input int id, input logic [4:0] rd, input logic [31:0] data, input bit we);
        bit bad, exp_wb;
        step();
        result_valid_i = 1'b1; result_id_i = 4'(id); result_rd_i = rd; result_data_i = data; result_we_i = we;
        sample();
        checks++;
        if (result_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL result_ready: got %b need 1", result_ready_o);
        end
        bad    = !live[id] || rd !== m_rd[id] || (we && !m_we[id]);
        exp_wb = !bad && we;
        live[id] = 1'b0;
        if (bad) exp_err = 1'b1;
        step();
        result_valid_i = 1'b0;
        sample();
        checks++;
        if (wb_valid_o !== exp_wb || (exp_wb && (wb_rd_o !== rd || wb_data_o !== data))) begin
            errors++;
            $display("FAIL wb id%0d: valid %b rd %0d data %h need %b %0d %h", id, wb_valid_o, wb_rd_o, wb_data_o, exp_wb, rd, data);
        end
        checks++;
        if (err_o !== exp_err || inflight_o !== 3'(live_count())) begin
            errors++;
            $display("FAIL result_state id%0d: err %b inflight %0d need %b %0d", id, err_o, inflight_o, exp_err, live_count());
        end
    endtask

    function automatic logic [31:0] rand_instr();
        return $urandom();
    endfunction

    task automatic test_reset();
        model_reset();
        sample();
        checks++;
        if ({req_ready_o, issue_valid_o, commit_valid_o, commit_kill_o, result_ready_o, wb_valid_o, illegal_o, err_o} !== 8'h0 || inflight_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: flags %b inflight %0d need 0", {req_ready_o, issue_valid_o, commit_valid_o, commit_kill_o, result_ready_o, wb_valid_o, illegal_o, err_o}, inflight_o);
        end
        step();
        rst_i = 1'b0;
        sample();
        checks++;
        if (req_ready_o !== 1'b1 || result_ready_o !== 1'b1 || issue_id_o !== 4'd0) begin
            errors++;
            $display("FAIL after_reset: req_ready %b result_ready %b id %0d need 1 1 0", req_ready_o, result_ready_o, issue_id_o);
        end
    endtask

    task automatic test_accept_write();
        int id;
        do_reset();
        do_req(32'h0000_0077, 32'd5, 32'd7, 1'b1, 1'b1, id);
        checks++;
        if (id !== 0) begin
            errors++;
            $display("FAIL accept_id: got %0d need 0", id);
        end
        send_result(0, 5'd0, 32'hC, 1'b1);
        step();
        sample();
        checks++;
        if (wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wb_pulse_width: got %b need 0", wb_valid_o);
        end
    endtask

    task automatic test_reject();
        int id;
        do_reset();
        do_req(rand_instr(), $urandom(), $urandom(), 1'b0, 1'b1, id);
        do_req(rand_instr(), $urandom(), $urandom(), 1'b1, 1'b0, id);
        checks++;
        if (id !== 1) begin
            errors++;
            $display("FAIL reject_next_id: got %0d need 1", id);
        end
        send_result(id, m_rd[id], $urandom(), 1'b0);
    endtask

    task automatic test_full();
        int ids[4];
        do_reset();
        for (int i = 0; i < 4; i++) do_req(rand_instr(), $urandom(), $urandom(), 1'b1, 1'b1, ids[i]);
        step();
        req_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if (req_ready_o !== 1'b0 || inflight_o !== 3'd4) begin
                errors++;
                $display("FAIL full_hold: req_ready %b inflight %0d need 0 4", req_ready_o, inflight_o);
            end
            if (i == 0) step();
        end
        req_valid_i = 1'b0;
        send_result(ids[2], m_rd[ids[2]], $urandom(), 1'b1);
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_release: req_ready %b need 1", req_ready_o);
        end
        foreach (ids[i]) if (live[ids[i]]) send_result(ids[i], m_rd[ids[i]], $urandom(), 1'b1);
    endtask

    task automatic test_out_of_order();
        int ids[3];
        do_reset();
        for (int i = 0; i < 3; i++) do_req(rand_instr(), $urandom(), $urandom(), 1'b1, 1'b1, ids[i]);
        send_result(ids[2], m_rd[ids[2]], $urandom(), 1'b1);
        send_result(ids[0], m_rd[ids[0]], $urandom(), 1'b1);
        send_result(ids[1], m_rd[ids[1]], $urandom(), 1'b1);
    endtask

    task automatic test_bad_result();
        int id;
        do_reset();
        do_req(rand_instr(), $urandom(), $urandom(), 1'b1, 1'b1, id);
        send_result(9, 5'd3, 32'hDEAD, 1'b1);
        send_result(id, m_rd[id], $urandom(), 1'b1);
    endtask

    task automatic test_wrap();
        int id;
        bit wb;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wb = 1'($urandom_range(0, 1));
            do_req(rand_instr(), $urandom(), $urandom(), 1'b1, wb, id);
            checks++;
            if (id !== i % 16) begin
                errors++;
                $display("FAIL wrap_id: got %0d need %0d", id, i % 16);
            end
            send_result(id, m_rd[id], $urandom(), wb);
        end
    endtask

    task automatic test_reset_mid_issue();
        int id;
        do_reset();
        for (int i = 0; i < 2; i++) do_req(rand_instr(), $urandom(), $urandom(), 1'b1, 1'b1, id);
        step();
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        sample();
        checks++;
        if (issue_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue_setup: issue_valid %b need 1", issue_valid_o);
        end
        issue_ready_i = 1'b1; issue_accept_i = 1'b1;
        rst_i = 1'b1;
        #1;
        checks++;
        if (issue_valid_o !== 1'b0 || inflight_o !== 3'd0) begin
            errors++;
            $display("FAIL mid_issue_reset: issue_valid %b inflight %0d need 0 0", issue_valid_o, inflight_o);
        end
        step();
        rst_i = 1'b0;
        issue_ready_i = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            sample();
            checks++;
            if (commit_valid_o !== 1'b0 || issue_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL no_commit_after_reset: commit %b issue %b need 0 0", commit_valid_o, issue_valid_o);
            end
            step();
        end
        do_req(rand_instr(), $urandom(), $urandom(), 1'b1, 1'b0, id);
        send_result(id, m_rd[id], $urandom(), 1'b0);
    endtask

    task automatic test_random();
        int id;
        int cand[$];
        do_reset();
        for (int it = 0; it < 80; it++) begin
            cand.delete();
            foreach (live[i]) if (live[i]) cand.push_back(i);
            if (cand.size() < 4 && (cand.size() == 0 || $urandom_range(0, 1) == 1)) begin
                do_req(rand_instr(), $urandom(), $urandom(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), id);
            end else if ($urandom_range(0, 9) == 0) begin
                send_result(int'($urandom_range(0, 15)), 5'($urandom()), $urandom(), 1'($urandom_range(0, 1)));
            end else begin
                id = cand[$urandom_range(0, cand.size() - 1)];
                send_result(id, m_rd[id], $urandom(), m_we[id] ? 1'($urandom_range(0, 1)) : 1'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_accept_write();
        test_reject();
        test_full();
        test_out_of_order();
        test_bad_result();
        test_wrap();
        test_reset_mid_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
